// File: rtl/ps2_kbd_rx_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard receiver.
//   ps2_state_e  - frame FSM states
//   PS2_PFX_*    - prefix bytes that modify the following key event
//   PS2_DROP_*   - keyboard status/response bytes that never become events
//   key_event_t  - 10-bit packed key event {pressed, extended, code}
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ps2_state_e;

   localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PFX_REL = 8'hF0;

   localparam logic [7:0] PS2_DROP_ACK    = 8'hFA;
   localparam logic [7:0] PS2_DROP_BATOK  = 8'hAA;
   localparam logic [7:0] PS2_DROP_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_DROP_RESEND = 8'hFE;
   localparam logic [7:0] PS2_DROP_ERR0   = 8'h00;
   localparam logic [7:0] PS2_DROP_ERR1   = 8'hFF;

   typedef struct packed {
      logic       pressed;
      logic       extended;
      logic [7:0] code;
   } key_event_t;

   // Keyboard housekeeping bytes are swallowed without touching the prefix flags.
   function automatic logic isDropCode(input logic [7:0] b);
      return (b == PS2_DROP_ACK)    || (b == PS2_DROP_BATOK) ||
             (b == PS2_DROP_ECHO)   || (b == PS2_DROP_RESEND) ||
             (b == PS2_DROP_ERR0)   || (b == PS2_DROP_ERR1);
   endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: key event handshake between the PS/2 receiver and the
// keyboard matrix logic.
//   key_valid    - event available (master -> slave)
//   key_ready    - consumer accepts the event (slave -> master)
//   key_code     - set 2 scancode with prefixes stripped
//   key_pressed  - 1 = make, 0 = break
//   key_extended - E0 prefix seen
interface ps2_kbd_rx_if;
   logic       key_valid;
   logic       key_ready;
   logic [7:0] key_code;
   logic       key_pressed;
   logic       key_extended;

   modport master (output key_valid, key_code, key_pressed, key_extended,
                   input  key_ready);
   modport slave  (input  key_valid, key_code, key_pressed, key_extended,
                   output key_ready);
endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous FIFO of key events with drop-on-full.
//   clk_sys, reset - system clock, async active-high reset
//   push_i/data_i  - write request and event
//   pop_i          - read request (ignored while empty)
//   data_o         - head event, valid while empty_o = 0
//   empty_o        - FIFO empty
//   overflow_o     - one-cycle pulse when a push is dropped
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       push_i,
   input  key_event_t data_i,
   input  logic       pop_i,
   output key_event_t data_o,
   output logic       empty_o,
   output logic       overflow_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   key_event_t    mem_q [DEPTH];
   logic [AW:0]   wrPtr_q, rdPtr_q;
   logic          overflow_q;
   logic          full, doPop, doPush;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full    = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                    (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign doPop   = pop_i & ~empty_o;
   // A pop in the same cycle frees the slot the push is about to use.
   assign doPush  = push_i & (~full | doPop);

   assign data_o     = mem_q[rdPtr_q[AW-1:0]];
   assign overflow_o = overflow_q;

   // Storage, pointers and the overflow pulse.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= push_i & full & ~doPop;
         if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= data_i;
            wrPtr_q <= wrPtr_q + (AW+1)'(1);
         end
         if (doPop) rdPtr_q <= rdPtr_q + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver running entirely on clk_sys.
// Deserialises 11-bit frames, checks odd parity and stop bit, folds E0/F0
// prefixes into one event per key and hands events to the keyboard matrix.
//   clk_sys, reset     - system clock, async active-high reset
//   ps2_clk, ps2_data  - PS/2 lines from HPS I/O (asynchronous, idle high)
//   kbd (master)       - key_valid/key_ready/key_code/key_pressed/key_extended
//   frame_err          - one-cycle pulse on bad frame or timeout
//   overflow           - one-cycle pulse when an event is dropped (FIFO build)
// Build option: define PS2_KBD_RX_FIFO_EN for a FIFO_DEPTH event FIFO with
// valid/ready handshake; otherwise key_valid is a single-cycle pulse.
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT    = 8000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   ps2_kbd_rx_if.master kbd,
   output logic frame_err,
   output logic overflow
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [1:0]  clkSync_q, dataSync_q;
   logic        clkPrev_q;
   logic        fall, dataBit;

   ps2_state_e  state_q;
   logic [7:0]  shift_q, byte_q;
   logic [2:0]  bitCnt_q;
   logic        parity_q, byteValid_q, frameErr_q;
   logic [TW-1:0] tmo_q;

   logic        ext_q, rel_q, ext_d, rel_d;
   logic        emit;
   key_event_t  evt;

   // Two-stage synchronisers plus a delayed copy of the clock for edge detection.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clkSync_q  <= 2'b11;
         dataSync_q <= 2'b11;
         clkPrev_q  <= 1'b1;
      end else begin
         clkSync_q  <= {clkSync_q[0], ps2_clk};
         dataSync_q <= {dataSync_q[0], ps2_data};
         clkPrev_q  <= clkSync_q[1];
      end
   end

   assign fall    = clkPrev_q & ~clkSync_q[1];
   assign dataBit = dataSync_q[1];

   // Frame FSM with the inactivity timeout. The timeout counter holds the number
   // of cycles since the last edge, so frame_err appears TIMEOUT cycles after it.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         byte_q      <= '0;
         bitCnt_q    <= '0;
         parity_q    <= 1'b0;
         byteValid_q <= 1'b0;
         frameErr_q  <= 1'b0;
         tmo_q       <= '0;
      end else begin
         byteValid_q <= 1'b0;
         frameErr_q  <= 1'b0;
         if (state_q == ST_IDLE)           tmo_q <= '0;
         else if (fall)                    tmo_q <= TW'(1);
         else if (tmo_q != TW'(TIMEOUT))   tmo_q <= tmo_q + TW'(1);

         if (fall) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (!dataBit) begin
                     state_q  <= ST_DATA;
                     bitCnt_q <= '0;
                  end
               end
               ST_DATA: begin
                  shift_q  <= {dataBit, shift_q[7:1]};
                  bitCnt_q <= bitCnt_q + 3'd1;
                  if (bitCnt_q == 3'd7) state_q <= ST_PARITY;
               end
               ST_PARITY: begin
                  parity_q <= dataBit;
                  state_q  <= ST_STOP;
               end
               ST_STOP: begin
                  if (dataBit && (^{shift_q, parity_q})) begin
                     byteValid_q <= 1'b1;
                     byte_q      <= shift_q;
                  end else begin
                     frameErr_q  <= 1'b1;
                  end
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT - 1)) begin
            frameErr_q <= 1'b1;
            state_q    <= ST_IDLE;
         end
      end
   end

   assign frame_err = frameErr_q;

   // Prefix decoder: E0/F0 only arm flags; any frame error also disarms them so
   // a half-received prefix sequence cannot leak into the next key.
   always_comb begin
      ext_d        = ext_q;
      rel_d        = rel_q;
      emit         = 1'b0;
      evt.pressed  = ~rel_q;
      evt.extended = ext_q;
      evt.code     = byte_q;
      if (frameErr_q) begin
         ext_d = 1'b0;
         rel_d = 1'b0;
      end else if (byteValid_q) begin
         if (byte_q == PS2_PFX_EXT)      ext_d = 1'b1;
         else if (byte_q == PS2_PFX_REL) rel_d = 1'b1;
         else if (!isDropCode(byte_q)) begin
            emit  = 1'b1;
            ext_d = 1'b0;
            rel_d = 1'b0;
         end
      end
   end

   // Prefix flag registers.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         ext_q <= 1'b0;
         rel_q <= 1'b0;
      end else begin
         ext_q <= ext_d;
         rel_q <= rel_d;
      end
   end

`ifdef PS2_KBD_RX_FIFO_EN
   key_event_t head;
   logic       fifoEmpty;

   ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .push_i     (emit),
      .data_i     (evt),
      .pop_i      (kbd.key_ready),
      .data_o     (head),
      .empty_o    (fifoEmpty),
      .overflow_o (overflow)
   );

   assign kbd.key_valid    = ~fifoEmpty;
   assign kbd.key_code     = head.code;
   assign kbd.key_pressed  = head.pressed;
   assign kbd.key_extended = head.extended;
`else
   key_event_t outEvt_q;
   logic       outValid_q;
   logic       unusedReady;

   // Single output register: fields hold until the next event, valid pulses once.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         outEvt_q   <= '0;
         outValid_q <= 1'b0;
      end else begin
         outValid_q <= emit;
         if (emit) outEvt_q <= evt;
      end
   end

   assign unusedReady      = kbd.key_ready;
   assign overflow         = 1'b0;
   assign kbd.key_valid    = outValid_q;
   assign kbd.key_code     = outEvt_q.code;
   assign kbd.key_pressed  = outEvt_q.pressed;
   assign kbd.key_extended = outEvt_q.extended;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Testbench for ps2_kbd_rx: table of byte sequences with expected key events,
// plus hand-written latency, timeout, reset and FIFO sequences.
module tb_ps2_kbd_rx;
   import ps2_pkg::*;

   localparam int TMO   = 200;
   localparam int DEPTH = 4;
   localparam int HALF  = 10;
`ifdef PS2_KBD_RX_FIFO_EN
   localparam bit FIFO_EN = 1'b1;
`else
   localparam bit FIFO_EN = 1'b0;
`endif

   typedef struct {
      logic [2:0][7:0] bytes;
      int              n;
      int              badIdx;
      int              expEvt;
      logic [7:0]      code;
      logic            pressed;
      logic            ext;
      int              expErr;
   } vec_t;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   logic ps2Clk  = 1'b1;
   logic ps2Data = 1'b1;
   logic frameErr, overflow;

   ps2_kbd_rx_if kif ();

   ps2_kbd_rx #(.TIMEOUT(TMO), .FIFO_DEPTH(DEPTH)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ps2_clk   (ps2Clk),
      .ps2_data  (ps2Data),
      .kbd       (kif),
      .frame_err (frameErr),
      .overflow  (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int passes = 0;
   key_event_t seen[$];
   key_event_t mon;
   int errCnt = 0;
   int ovfCnt = 0;
   vec_t vecs[11];

   // Monitor: records accepted events and counts error/overflow pulses.
   always @(negedge clk_sys) begin
      if (!reset) begin
         if (kif.key_valid && (kif.key_ready || !FIFO_EN)) begin
            mon.code     = kif.key_code;
            mon.pressed  = kif.key_pressed;
            mon.extended = kif.key_extended;
            seen.push_back(mon);
         end
         if (frameErr) errCnt++;
         if (overflow) ovfCnt++;
      end
   end

   function automatic vec_t mkVec(int n, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                  int bad, int expEvt, logic [7:0] code,
                                  logic pr, logic ex, int expErr);
      vec_t v;
      v.bytes = {b2, b1, b0};
      v.n = n; v.badIdx = bad; v.expEvt = expEvt;
      v.code = code; v.pressed = pr; v.ext = ex; v.expErr = expErr;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic pulseBit(input logic b);
      ps2Data = b;
      waitCycles(5);
      ps2Clk = 1'b0;
      waitCycles(HALF);
      ps2Clk = 1'b1;
      waitCycles(5);
   endtask

   task automatic sendByte(input logic [7:0] b, input logic flip);
      pulseBit(1'b0);
      for (int i = 0; i < 8; i++) pulseBit(b[i]);
      pulseBit((~^b) ^ flip);
      pulseBit(1'b1);
   endtask

   task automatic applyStimulus(input vec_t v);
      for (int i = 0; i < v.n; i++) sendByte(v.bytes[i], (i == v.badIdx));
      waitCycles(10);
   endtask

   initial begin
      int base, eBase, oBase;
      logic [7:0] fifoExp [5];

      vecs[0]  = mkVec(1, 8'h1C, 8'h00, 8'h00, -1, 1, 8'h1C, 1'b1, 1'b0, 0);
      vecs[1]  = mkVec(2, 8'hF0, 8'h1C, 8'h00, -1, 1, 8'h1C, 1'b0, 1'b0, 0);
      vecs[2]  = mkVec(3, 8'hE0, 8'hF0, 8'h74, -1, 1, 8'h74, 1'b0, 1'b1, 0);
      vecs[3]  = mkVec(1, 8'h1C, 8'h00, 8'h00, -1, 1, 8'h1C, 1'b1, 1'b0, 0);
      vecs[4]  = mkVec(1, 8'h1C, 8'h00, 8'h00,  0, 0, 8'h00, 1'b0, 1'b0, 1);
      vecs[5]  = mkVec(2, 8'hE0, 8'h72, 8'h00, -1, 1, 8'h72, 1'b1, 1'b1, 0);
      vecs[6]  = mkVec(3, 8'hF0, 8'h1C, 8'h1C,  1, 1, 8'h1C, 1'b1, 1'b0, 1);
      vecs[7]  = mkVec(3, 8'hF0, 8'hAA, 8'h1C, -1, 1, 8'h1C, 1'b0, 1'b0, 0);
      vecs[8]  = mkVec(1, 8'hE1, 8'h00, 8'h00, -1, 1, 8'hE1, 1'b1, 1'b0, 0);
      vecs[9]  = mkVec(3, 8'h00, 8'hFA, 8'h15, -1, 1, 8'h15, 1'b1, 1'b0, 0);
      vecs[10] = mkVec(3, 8'hE0, 8'hFF, 8'h6B, -1, 1, 8'h6B, 1'b1, 1'b1, 0);
      fifoExp = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h2D};

      kif.key_ready = 1'b1;
      waitCycles(3);
      checkOutput("rst_valid",    32'(kif.key_valid),    32'd0);
      checkOutput("rst_code",     32'(kif.key_code),     32'd0);
      checkOutput("rst_pressed",  32'(kif.key_pressed),  32'd0);
      checkOutput("rst_extended", 32'(kif.key_extended), 32'd0);
      checkOutput("rst_frameerr", 32'(frameErr),         32'd0);
      checkOutput("rst_overflow", 32'(overflow),         32'd0);
      reset = 1'b0;
      waitCycles(5);

      // Latency: key_valid exactly at E+2 (4 cycles after the pin falls).
      pulseBit(1'b0);
      for (int i = 0; i < 8; i++) pulseBit(1'(8'h1C >> i));
      pulseBit(1'b0);
      ps2Data = 1'b1;
      waitCycles(5);
      ps2Clk = 1'b0;
      waitCycles(3);
      checkOutput("lat_valid_e1", 32'(kif.key_valid), 32'd0);
      waitCycles(1);
      checkOutput("lat_valid_e2", 32'(kif.key_valid), 32'd1);
      checkOutput("lat_code",     32'(kif.key_code),  32'h1C);
      waitCycles(1);
      checkOutput("lat_valid_e3", 32'(kif.key_valid), 32'd0);
      waitCycles(HALF - 5);
      ps2Clk = 1'b1;
      waitCycles(10);

      // Table-driven byte sequences.
      for (int k = 0; k < 11; k++) begin
         base  = seen.size();
         eBase = errCnt;
         applyStimulus(vecs[k]);
         checkOutput($sformatf("v%0d_events", k), 32'(seen.size() - base), 32'(vecs[k].expEvt));
         checkOutput($sformatf("v%0d_errors", k), 32'(errCnt - eBase),     32'(vecs[k].expErr));
         if (vecs[k].expEvt == 1 && seen.size() > base) begin
            checkOutput($sformatf("v%0d_code", k),    32'(seen[base].code),     32'(vecs[k].code));
            checkOutput($sformatf("v%0d_pressed", k), 32'(seen[base].pressed),  32'(vecs[k].pressed));
            checkOutput($sformatf("v%0d_ext", k),     32'(seen[base].extended), 32'(vecs[k].ext));
         end
      end

      // Timeout: start plus 4 data bits, then silence.
      eBase = errCnt;
      base  = seen.size();
      pulseBit(1'b0);
      pulseBit(1'b1);
      pulseBit(1'b0);
      pulseBit(1'b1);
      ps2Data = 1'b1;
      waitCycles(5);
      ps2Clk = 1'b0;
      waitCycles(HALF);
      ps2Clk = 1'b1;
      waitCycles(TMO + 1 - HALF);
      checkOutput("tmo_before", 32'(frameErr), 32'd0);
      waitCycles(1);
      checkOutput("tmo_pulse",  32'(frameErr), 32'd1);
      waitCycles(1);
      checkOutput("tmo_after",  32'(frameErr), 32'd0);
      waitCycles(10);
      sendByte(8'h29, 1'b0);
      waitCycles(10);
      checkOutput("tmo_errors", 32'(errCnt - eBase),     32'd1);
      checkOutput("tmo_events", 32'(seen.size() - base), 32'd1);
      if (seen.size() > base) checkOutput("tmo_next_code", 32'(seen[base].code), 32'h29);

      // Reset in the middle of a frame discards the partial byte.
      pulseBit(1'b0);
      pulseBit(1'b1);
      pulseBit(1'b1);
      reset = 1'b1;
      waitCycles(3);
      checkOutput("midrst_valid", 32'(kif.key_valid), 32'd0);
      reset = 1'b0;
      waitCycles(3);
      base  = seen.size();
      eBase = errCnt;
      sendByte(8'h34, 1'b0);
      waitCycles(10);
      checkOutput("midrst_events", 32'(seen.size() - base), 32'd1);
      checkOutput("midrst_errors", 32'(errCnt - eBase),     32'd0);
      if (seen.size() > base) checkOutput("midrst_code", 32'(seen[base].code), 32'h34);

      if (FIFO_EN) begin
         // Fill past capacity with the consumer stalled.
         kif.key_ready = 1'b0;
         base  = seen.size();
         oBase = ovfCnt;
         sendByte(8'h15, 1'b0);
         sendByte(8'h16, 1'b0);
         sendByte(8'h1E, 1'b0);
         sendByte(8'h26, 1'b0);
         sendByte(8'h25, 1'b0);
         waitCycles(10);
         checkOutput("fifo_ovf",       32'(ovfCnt - oBase), 32'd1);
         checkOutput("fifo_valid",     32'(kif.key_valid),  32'd1);
         checkOutput("fifo_head_code", 32'(kif.key_code),   32'h15);
         // Push while full with a pop in the very same cycle (E+1).
         pulseBit(1'b0);
         for (int i = 0; i < 8; i++) pulseBit(1'(8'h2D >> i));
         pulseBit(~^8'h2D);
         ps2Data = 1'b1;
         waitCycles(5);
         ps2Clk = 1'b0;
         waitCycles(3);
         kif.key_ready = 1'b1;
         waitCycles(1);
         kif.key_ready = 1'b0;
         waitCycles(HALF - 4);
         ps2Clk = 1'b1;
         waitCycles(10);
         checkOutput("fifo_pushpop_ovf", 32'(ovfCnt - oBase), 32'd1);
         kif.key_ready = 1'b1;
         waitCycles(10);
         checkOutput("fifo_drain_count", 32'(seen.size() - base), 32'd5);
         for (int i = 0; i < 5; i++)
            if (seen.size() > base + i)
               checkOutput($sformatf("fifo_order%0d", i), 32'(seen[base + i].code), 32'(fifoExp[i]));
         checkOutput("fifo_empty", 32'(kif.key_valid), 32'd0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

Receives the serial PS/2 keyboard stream that the HPS I/O block emits on its keyboard clock/data outputs. It deserializes and checks each 11-bit frame, folds the E0/F0 prefixes into one key event per key, and buffers the events for the SAM Coupé keyboard matrix logic. It sits between the HPS I/O block and the core's keyboard matrix. It runs entirely on the system clock, with no PS/2 clock domain.

## Interface
Parameters:
- TIMEOUT, 8000: clk_sys cycles with no falling ps2_clk edge before an in-progress frame is abandoned. Must exceed 4×PS2DIV.
- FIFO_DEPTH, 4: event FIFO entries; power of two, ≥2. Used only with the FIFO macro.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- ps2_clk, in, 1: PS/2 clock from HPS I/O; idles high.
- ps2_data, in, 1: PS/2 data from HPS I/O.
- key_valid, out, 1: event available.
- key_ready, in, 1: consumer accepts the event.
- key_code, out, 8: scancode (set 2, prefix stripped).
- key_pressed, out, 1: 1 = make, 0 = break (F0 seen).
- key_extended, out, 1: E0 prefix seen.
- frame_err, out, 1: one-cycle pulse on a bad frame or timeout.
- overflow, out, 1: one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Input conditioning:
  - ps2_clk and ps2_data pass through 2-FF synchronizers, reset to 1.
  - A falling edge is sync_clk_prev=1 and sync_clk=0. Call that cycle E.
  - Data is sampled in cycle E.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data=0 (start bit), go to DATA with bit count 0. On an edge with data=1, stay in IDLE with no error (glitch).
  - DATA: shift data in LSB-first. After the 8th bit go to PARITY.
  - PARITY: capture the parity bit, go to STOP. Parity is odd: the 8 data bits plus the parity bit must contain an odd number of 1s.
  - STOP: if stop=1 and parity is good, present the byte to the decoder in cycle E+1. Otherwise pulse frame_err, discard the byte and clear the prefix flags. Return to IDLE in both cases.
- Timeout:
  - Counter clears on every falling edge and in IDLE, and saturates.
  - When it reaches TIMEOUT outside IDLE: pulse frame_err, go to IDLE, clear the prefix flags.
- Decoder, on each good byte:
  - E0: set ext, no event.
  - F0: set rel, no event.
  - FA, AA, EE, FE, 00, FF: dropped, flags unchanged.
  - Any other byte: emit {code=byte, pressed=~rel, extended=ext} and clear ext and rel.
  - E1 is emitted as an ordinary code.
- Events are pushed into the output stage in cycle E+2.

## Timing
- Latency: stop-bit falling edge on the pin → synchronizer 2 cycles → E → byte at E+1 → key_valid at E+2.
- Handshake (FIFO build): key_valid = FIFO not empty.
  - key_code, key_pressed and key_extended are stable while key_valid=1 and key_ready=0.
  - Pop when key_valid && key_ready.
- FIFO boundaries:
  - Full with a push and no pop: drop the new event and pulse overflow.
  - Full with push and pop in the same cycle: both happen, no overflow.
  - Empty with a push: key_valid rises the next cycle. There is no bypass.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset values:
  - Outputs key_valid, key_code, key_pressed, key_extended, frame_err and overflow are all 0.
  - FSM in IDLE; ext, rel and the counters are 0; FIFO is empty.
- Reset mid-frame discards the partial byte and any queued events. Reception restarts on the next start bit.

## Configuration
- Macro PS2_KBD_RX_FIFO_EN.
- Defined: event FIFO of FIFO_DEPTH entries with the valid/ready handshake described above.
- Undefined:
  - Single output register; key_valid is a one-cycle pulse at E+2.
  - key_ready is ignored; overflow is tied to 0.
  - The output fields hold their last value until the next event.
- The port list is identical in both builds.

## Structure
- Package ps2_pkg:
  - FSM state enum.
  - Constants PS2_PFX_EXT=8'hE0 and PS2_PFX_REL=8'hF0.
  - Drop-code constants.
  - Packed struct key_event_t {pressed, extended, code[7:0]}, 10 bits.
- Sub-module ps2_event_fifo: synchronous FIFO of key_event_t with push, pop, full, empty and drop-on-full. Instantiated only under PS2_KBD_RX_FIFO_EN.

## Test plan
- Frame 1C with good parity (parity bit 0), key_ready=1 → one event {1C, pressed=1, ext=0}; key_valid is high exactly 2 cycles after the stop edge is detected.
- Bytes F0 then 1C → a single event {1C, pressed=0, ext=0}.
- Bytes E0, F0, 74 → a single event {74, pressed=0, ext=1}; ext and rel are cleared afterwards.
- Frame 1C with parity bit flipped → frame_err pulse, no event. A following E0 72 yields {72, 1, ext=1} with no stale rel.
- Start, 4 data bits, then silence for TIMEOUT+10 cycles → frame_err at exactly TIMEOUT cycles after the last edge, FSM back in IDLE. The next full frame (code 29) decodes correctly.
- FIFO build: key_ready=0, send FIFO_DEPTH+1 make codes → FIFO_DEPTH events retained in order and one overflow pulse. Then key_ready=1 drains them. Also check a push and pop in the same cycle while full produces no overflow.
